// File: rtl/lcd_responder_if.sv
// LCD pin bundle between the host controller and the responder.
interface lcd_responder_if;
  logic       LCD_E;
  logic       LCD_RS;
  logic       LCD_RW;
  logic [7:0] LCD_DATA_IN;
  logic [7:0] LCD_DATA_OUT;
  logic       LCD_DATA_OE;

  modport master (
    output LCD_E, LCD_RS, LCD_RW, LCD_DATA_IN,
    input  LCD_DATA_OUT, LCD_DATA_OE
  );

  modport slave (
    input  LCD_E, LCD_RS, LCD_RW, LCD_DATA_IN,
    output LCD_DATA_OUT, LCD_DATA_OE
  );
endinterface

// File: rtl/lcd_responder.sv
// HD44780-style character LCD responder: synchronizes the host strobe,
// executes instruction/data accesses against an 80-byte DDRAM and
// models the busy flag, including the 80-cycle clear sweep.
module lcd_responder #(
  parameter int unsigned BUSY_CYCLES = 4,
  parameter int unsigned HOME_CYCLES = 40
) (
  input  logic           CLK,
  input  logic           RESET,
  lcd_responder_if.slave lcd,
  output logic           BUSY,
  output logic           DISP_ON,
  output logic [6:0]     CURSOR_ADDR,
  output logic [5:0]     SHIFT_OFS,
  output logic           DROP,
  input  logic [6:0]     RD_ADDR,
  output logic [7:0]     RD_CHAR
);

  localparam int unsigned DD_DEPTH = 80;
  localparam int unsigned IDX_W    = 7;
  localparam int unsigned CNT_W    = 16;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] EXEC  = 2'd1;
  localparam logic [1:0] BUSYW = 2'd2;
  localparam logic [1:0] CLEAR = 2'd3;

  // Address counter steps skip the hole between the two display lines.
  function automatic logic [6:0] ac_inc(input logic [6:0] a);
    if (a == 7'h27)      return 7'h40;
    else if (a == 7'h67) return 7'h00;
    else                 return a + 7'd1;
  endfunction

  function automatic logic [6:0] ac_dec(input logic [6:0] a);
    if (a == 7'h40)      return 7'h27;
    else if (a == 7'h00) return 7'h67;
    else                 return a - 7'd1;
  endfunction

  function automatic logic [6:0] ac_set(input logic [6:0] a);
    if (a >= 7'h28 && a <= 7'h3F) return 7'h40;
    else if (a >= 7'h68)          return 7'h00;
    else                          return a;
  endfunction

  function automatic logic [5:0] ofs_inc(input logic [5:0] o);
    return (o == 6'd39) ? 6'd0 : o + 6'd1;
  endfunction

  function automatic logic [5:0] ofs_dec(input logic [5:0] o);
    return (o == 6'd0) ? 6'd39 : o - 6'd1;
  endfunction

  // Line 1 occupies entries 0..39, line 2 entries 40..79.
  function automatic logic [IDX_W-1:0] to_idx(input logic [6:0] a);
    return a[6] ? ({1'b0, a[5:0]} + 7'd40) : {1'b0, a[5:0]};
  endfunction

  function automatic logic addr_ok(input logic [6:0] a);
    return (a < 7'h28) || (a >= 7'h40 && a < 7'h68);
  endfunction

  logic [1:0]       state, state_nxt;
  logic             e_s1, e_s2, e_d, rs_s1, rs_s2, rw_s1, rw_s2;
  logic [7:0]       din_s1, din_s2;
  logic             e_fall;
  logic             cmd_rs, cmd_rw;
  logic [7:0]       cmd_data;
  logic [6:0]       ac_q, ac_nxt;
  logic [5:0]       ofs_q, ofs_nxt;
  logic             disp_q, disp_nxt, id_q, id_nxt, sh_q, sh_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [IDX_W-1:0] clr_q, clr_nxt;
  logic             drop_q, drop_nxt, busy_q;
  logic [7:0]       dout_q;
  logic             oe_q;
  logic             mem_we;
  logic [IDX_W-1:0] mem_idx;
  logic [7:0]       mem_wdata;
  logic [7:0]       ddram [DD_DEPTH];

  assign e_fall           = e_d & ~e_s2;
  assign BUSY             = busy_q;
  assign DISP_ON          = disp_q;
  assign CURSOR_ADDR      = ac_q;
  assign SHIFT_OFS        = ofs_q;
  assign DROP             = drop_q;
  assign lcd.LCD_DATA_OUT = dout_q;
  assign lcd.LCD_DATA_OE  = oe_q;
  assign RD_CHAR          = addr_ok(RD_ADDR) ? ddram[to_idx(RD_ADDR)] : 8'h00;

  // Two-flop synchronizers for the asynchronous host pins.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      e_s1 <= 1'b0; e_s2 <= 1'b0; e_d <= 1'b0;
      rs_s1 <= 1'b0; rs_s2 <= 1'b0;
      rw_s1 <= 1'b0; rw_s2 <= 1'b0;
      din_s1 <= 8'h00; din_s2 <= 8'h00;
    end else begin
      e_s1 <= lcd.LCD_E;       e_s2 <= e_s1;  e_d <= e_s2;
      rs_s1 <= lcd.LCD_RS;     rs_s2 <= rs_s1;
      rw_s1 <= lcd.LCD_RW;     rw_s2 <= rw_s1;
      din_s1 <= lcd.LCD_DATA_IN; din_s2 <= din_s1;
    end
  end

  // FSM state register; reset lands in CLEAR so the sweep runs on release.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= CLEAR;
    else       state <= state_nxt;
  end

  // Next-state, register updates and DDRAM write port selection.
  always_comb begin
    state_nxt = state;
    ac_nxt    = ac_q;
    ofs_nxt   = ofs_q;
    disp_nxt  = disp_q;
    id_nxt    = id_q;
    sh_nxt    = sh_q;
    cnt_nxt   = cnt_q;
    clr_nxt   = clr_q;
    drop_nxt  = 1'b0;
    mem_we    = 1'b0;
    mem_idx   = clr_q;
    mem_wdata = 8'h20;
    case (state)
      IDLE: if (e_fall) state_nxt = EXEC;
      EXEC: begin
        if (cmd_rw) begin
          state_nxt = IDLE;
          if (cmd_rs) ac_nxt = id_q ? ac_inc(ac_q) : ac_dec(ac_q);
        end else if (cmd_rs) begin
          mem_we    = 1'b1;
          mem_idx   = to_idx(ac_q);
          mem_wdata = cmd_data;
          ac_nxt    = id_q ? ac_inc(ac_q) : ac_dec(ac_q);
          if (sh_q) ofs_nxt = id_q ? ofs_inc(ofs_q) : ofs_dec(ofs_q);
          cnt_nxt   = CNT_W'(BUSY_CYCLES - 1);
          state_nxt = BUSYW;
        end else if (cmd_data == 8'h01) begin
          ac_nxt    = 7'h00;
          ofs_nxt   = 6'd0;
          id_nxt    = 1'b1;
          clr_nxt   = '0;
          state_nxt = CLEAR;
        end else begin
          cnt_nxt   = CNT_W'(BUSY_CYCLES - 1);
          state_nxt = BUSYW;
          casez (cmd_data)
            8'b1???????: ac_nxt = ac_set(cmd_data[6:0]);
            8'b0001????: begin
              if (cmd_data[3]) ofs_nxt = cmd_data[2] ? ofs_inc(ofs_q) : ofs_dec(ofs_q);
              else             ac_nxt  = cmd_data[2] ? ac_inc(ac_q) : ac_dec(ac_q);
            end
            8'b00001???: disp_nxt = cmd_data[2];
            8'b000001??: begin
              id_nxt = cmd_data[1];
              sh_nxt = cmd_data[0];
            end
            8'b0000001?: begin
              ac_nxt  = 7'h00;
              ofs_nxt = 6'd0;
              cnt_nxt = CNT_W'(HOME_CYCLES - 1);
            end
            default: ; // CGRAM address, function set, NOP: busy only
          endcase
        end
      end
      BUSYW: begin
        if (cnt_q == '0) state_nxt = IDLE;
        else             cnt_nxt   = cnt_q - 1'b1;
      end
      CLEAR: begin
        mem_we  = 1'b1;
        clr_nxt = clr_q + 7'd1;
        if (clr_q == 7'(DD_DEPTH - 1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Strobes landing while busy: writes are dropped, data reads still step AC.
    if (e_fall && state != IDLE) begin
      if (!rw_s2)                      drop_nxt = 1'b1;
      else if (rs_s2 && state != EXEC) ac_nxt   = id_q ? ac_inc(ac_q) : ac_dec(ac_q);
    end
  end

  // Architectural registers, command latch and read-back bus.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ac_q     <= 7'h00;
      ofs_q    <= 6'd0;
      disp_q   <= 1'b0;
      id_q     <= 1'b1;
      sh_q     <= 1'b0;
      cnt_q    <= '0;
      clr_q    <= '0;
      drop_q   <= 1'b0;
      busy_q   <= 1'b1;
      dout_q   <= 8'h00;
      oe_q     <= 1'b0;
      cmd_rs   <= 1'b0;
      cmd_rw   <= 1'b0;
      cmd_data <= 8'h00;
    end else begin
      ac_q   <= ac_nxt;
      ofs_q  <= ofs_nxt;
      disp_q <= disp_nxt;
      id_q   <= id_nxt;
      sh_q   <= sh_nxt;
      cnt_q  <= cnt_nxt;
      clr_q  <= clr_nxt;
      drop_q <= drop_nxt;
      busy_q <= (state_nxt == BUSYW) || (state_nxt == CLEAR);
      oe_q   <= e_s2 & rw_s2;
      if (e_s2 && rw_s2) dout_q <= rs_s2 ? ddram[to_idx(ac_q)] : {busy_q, ac_q};
      if (e_fall && state == IDLE) begin
        cmd_rs   <= rs_s2;
        cmd_rw   <= rw_s2;
        cmd_data <= din_s2;
      end
    end
  end

  // DDRAM storage; contents are initialised by the clear sweep, not by reset.
  always_ff @(posedge CLK) begin
    if (mem_we) ddram[mem_idx] <= mem_wdata;
  end

endmodule

// File: tb/tb_lcd_responder.sv
// Self-checking bench for lcd_responder: table of accesses plus hand-written
// busy/drop/read/reset sequences, checked through an expectation queue.
module tb_lcd_responder;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       BUSY, DISP_ON, DROP;
  logic [6:0] CURSOR_ADDR;
  logic [5:0] SHIFT_OFS;
  logic [6:0] RD_ADDR = 7'h00;
  logic [7:0] RD_CHAR;

  always #5 CLK = ~CLK;

  lcd_responder_if lcd();

  lcd_responder #(.BUSY_CYCLES(4), .HOME_CYCLES(40)) dut (
    .CLK(CLK), .RESET(RESET), .lcd(lcd), .BUSY(BUSY), .DISP_ON(DISP_ON),
    .CURSOR_ADDR(CURSOR_ADDR), .SHIFT_OFS(SHIFT_OFS), .DROP(DROP),
    .RD_ADDR(RD_ADDR), .RD_CHAR(RD_CHAR)
  );

  typedef struct { string name; int unsigned exp; } sb_t;
  typedef struct {
    logic rs; logic [7:0] d; logic [6:0] ac; logic [5:0] ofs; logic disp;
    logic chk; logic [6:0] addr; logic [7:0] ch;
  } vec_t;

  sb_t  sb[$];
  vec_t vt[18];
  int   errors = 0;
  int   checks = 0;
  int   drop_cnt = 0;

  always @(negedge CLK) if (DROP === 1'b1) drop_cnt++;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic sb_push(input string name, input int unsigned exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic sb_check(input int unsigned act);
    sb_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_empty actual=%0h", act);
    end else begin
      e = sb.pop_front();
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s actual=%0h expected=%0h", e.name, act, e.exp);
      end
    end
  endtask

  task automatic setv(input int i, input logic rs, input logic [7:0] d, input logic [6:0] ac,
                      input logic [5:0] ofs, input logic disp, input logic chk,
                      input logic [6:0] addr, input logic [7:0] ch);
    vt[i].rs = rs; vt[i].d = d; vt[i].ac = ac; vt[i].ofs = ofs; vt[i].disp = disp;
    vt[i].chk = chk; vt[i].addr = addr; vt[i].ch = ch;
  endtask

  task automatic access(input logic rs, input logic rw, input logic [7:0] d);
    @(negedge CLK);
    lcd.LCD_RS = rs; lcd.LCD_RW = rw; lcd.LCD_DATA_IN = d;
    repeat (2) @(negedge CLK);
    lcd.LCD_E = 1'b1;
    repeat (6) @(negedge CLK);
    lcd.LCD_E = 1'b0;
    repeat (3) @(negedge CLK);
  endtask

  task automatic read_acc(input logic rs, output logic [7:0] dout, output logic oe);
    @(negedge CLK);
    lcd.LCD_RS = rs; lcd.LCD_RW = 1'b1; lcd.LCD_DATA_IN = 8'h00;
    repeat (2) @(negedge CLK);
    lcd.LCD_E = 1'b1;
    repeat (5) @(negedge CLK);
    dout = lcd.LCD_DATA_OUT;
    oe   = lcd.LCD_DATA_OE;
    @(negedge CLK);
    lcd.LCD_E = 1'b0;
    repeat (3) @(negedge CLK);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    repeat (2) @(negedge CLK);
    while (BUSY && n < 300) begin @(negedge CLK); n++; end
    if (BUSY) begin
      errors++; checks++;
      $display("FAIL %s_timeout busy actual=1 expected=0", name);
    end
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (BUSY && n < 300) begin n++; @(negedge CLK); end
  endtask

  task automatic measure_busy(output int n);
    int k = 0;
    while (!BUSY && k < 20) begin @(negedge CLK); k++; end
    count_busy(n);
  endtask

  task automatic check_blank(input string name);
    int bad = 0;
    sb_push(name, 0);
    for (int a = 0; a < 128; a++) begin
      RD_ADDR = 7'(a);
      #1;
      if ((a < 8'h28 || (a >= 8'h40 && a < 8'h68)) && RD_CHAR !== 8'h20) bad++;
    end
    sb_check(bad);
  endtask

  task automatic peek(input string name, input logic [6:0] addr, input logic [7:0] exp);
    sb_push(name, exp);
    RD_ADDR = addr;
    #1;
    sb_check(RD_CHAR);
  endtask

  initial begin
    int          n;
    int          d0;
    logic [7:0]  dout;
    logic        oe;

    //     i   rs    data    ac     ofs disp chk  addr   char
    setv(0,  1'b0, 8'h06, 7'h00, 6'd0, 1'b0, 1'b0, 7'h00, 8'h00);
    setv(1,  1'b0, 8'h80, 7'h00, 6'd0, 1'b0, 1'b0, 7'h00, 8'h00);
    setv(2,  1'b1, 8'h32, 7'h01, 6'd0, 1'b0, 1'b1, 7'h00, 8'h32);
    setv(3,  1'b1, 8'h30, 7'h02, 6'd0, 1'b0, 1'b1, 7'h01, 8'h30);
    setv(4,  1'b0, 8'h0C, 7'h02, 6'd0, 1'b1, 1'b0, 7'h00, 8'h00);
    setv(5,  1'b0, 8'hA7, 7'h27, 6'd0, 1'b1, 1'b0, 7'h00, 8'h00);
    setv(6,  1'b1, 8'h41, 7'h40, 6'd0, 1'b1, 1'b1, 7'h27, 8'h41);
    setv(7,  1'b0, 8'hB0, 7'h40, 6'd0, 1'b1, 1'b0, 7'h00, 8'h00);
    setv(8,  1'b0, 8'h10, 7'h27, 6'd0, 1'b1, 1'b0, 7'h00, 8'h00);
    setv(9,  1'b0, 8'h14, 7'h40, 6'd0, 1'b1, 1'b0, 7'h00, 8'h00);
    setv(10, 1'b0, 8'hFF, 7'h00, 6'd0, 1'b1, 1'b0, 7'h00, 8'h00);
    setv(11, 1'b0, 8'h04, 7'h00, 6'd0, 1'b1, 1'b0, 7'h00, 8'h00);
    setv(12, 1'b1, 8'h32, 7'h67, 6'd0, 1'b1, 1'b1, 7'h00, 8'h32);
    setv(13, 1'b0, 8'h0A, 7'h67, 6'd0, 1'b0, 1'b0, 7'h00, 8'h00);
    setv(14, 1'b0, 8'h07, 7'h67, 6'd0, 1'b0, 1'b0, 7'h00, 8'h00);
    setv(15, 1'b1, 8'h42, 7'h00, 6'd1, 1'b0, 1'b1, 7'h67, 8'h42);
    setv(16, 1'b0, 8'h02, 7'h00, 6'd0, 1'b0, 1'b0, 7'h00, 8'h00);
    setv(17, 1'b0, 8'h06, 7'h00, 6'd0, 1'b0, 1'b0, 7'h00, 8'h00);

    lcd.LCD_E = 1'b0; lcd.LCD_RS = 1'b0; lcd.LCD_RW = 1'b0; lcd.LCD_DATA_IN = 8'h00;

    // Values held while reset is asserted.
    repeat (3) @(negedge CLK);
    sb_push("rst_busy", 1);  sb_check(BUSY);
    sb_push("rst_ac", 0);    sb_check(CURSOR_ADDR);
    sb_push("rst_ofs", 0);   sb_check(SHIFT_OFS);
    sb_push("rst_disp", 0);  sb_check(DISP_ON);
    sb_push("rst_drop", 0);  sb_check(DROP);
    sb_push("rst_oe", 0);    sb_check(lcd.LCD_DATA_OE);
    sb_push("rst_dout", 0);  sb_check(lcd.LCD_DATA_OUT);

    // Power-on sweep.
    RESET = 1'b0;
    sb_push("por_busy_len", 80);
    count_busy(n);
    sb_check(n);
    check_blank("por_blank_bad");
    sb_push("por_ac", 0);    sb_check(CURSOR_ADDR);

    // Table of writes with expected architectural state afterwards.
    foreach (vt[i]) begin
      sb_push($sformatf("v%0d_ac", i), vt[i].ac);
      sb_push($sformatf("v%0d_ofs", i), vt[i].ofs);
      sb_push($sformatf("v%0d_disp", i), vt[i].disp);
      access(vt[i].rs, 1'b0, vt[i].d);
      wait_idle($sformatf("v%0d", i));
      sb_check(CURSOR_ADDR);
      sb_check(SHIFT_OFS);
      sb_check(DISP_ON);
      if (vt[i].chk) peek($sformatf("v%0d_ddram", i), vt[i].addr, vt[i].ch);
    end

    // Busy durations for an ordinary command and for return-home.
    sb_push("busy_len_cmd", 4);
    access(1'b0, 1'b0, 8'h0C);
    measure_busy(n);
    sb_check(n);
    sb_push("busy_len_home", 40);
    access(1'b0, 1'b0, 8'h02);
    measure_busy(n);
    sb_check(n);

    // Display shift left 40 times wraps 39..0, then one right shift.
    for (int i = 1; i <= 40; i++) begin
      sb_push($sformatf("shl%0d_ofs", i), (40 - i) % 40);
      access(1'b0, 1'b0, 8'h18);
      wait_idle("shl");
      sb_check(SHIFT_OFS);
    end
    sb_push("shr_ofs", 1);
    access(1'b0, 1'b0, 8'h1C);
    wait_idle("shr");
    sb_check(SHIFT_OFS);

    // Data read at AC=0 (holds 0x32), then AC advances and OE releases.
    sb_push("rd_data", 8'h32);
    sb_push("rd_oe", 1);
    read_acc(1'b1, dout, oe);
    sb_check(dout);
    sb_check(oe);
    wait_idle("rd");
    sb_push("rd_ac_after", 1);     sb_check(CURSOR_ADDR);
    sb_push("rd_oe_after", 0);     sb_check(lcd.LCD_DATA_OE);
    sb_push("rd_ofs_after", 1);    sb_check(SHIFT_OFS);

    // Busy-flag read and dropped write during a return-home busy period.
    d0 = drop_cnt;
    sb_push("bf_read", 8'h80);
    sb_push("bf_oe", 1);
    access(1'b0, 1'b0, 8'h02);
    read_acc(1'b0, dout, oe);
    sb_check(dout);
    sb_check(oe);
    sb_push("drop_pulses", 1);
    access(1'b1, 1'b0, 8'h99);
    wait_idle("drop");
    sb_check(drop_cnt - d0);
    sb_push("drop_ac", 0);  sb_check(CURSOR_ADDR);
    peek("drop_ddram", 7'h00, 8'h32);

    // Clear command from a non-zero AC and offset.
    access(1'b0, 1'b0, 8'h90);
    wait_idle("pre_clr_ac");
    access(1'b0, 1'b0, 8'h1C);
    wait_idle("pre_clr_ofs");
    sb_push("clr_busy_len", 80);
    access(1'b0, 1'b0, 8'h01);
    measure_busy(n);
    sb_check(n);
    sb_push("clr_ac", 0);   sb_check(CURSOR_ADDR);
    sb_push("clr_ofs", 0);  sb_check(SHIFT_OFS);
    check_blank("clr_blank_bad");

    // Reset in the middle of a clear restarts the full sweep.
    access(1'b1, 1'b0, 8'h5A);
    wait_idle("pre_rst_data");
    access(1'b0, 1'b0, 8'h0C);
    wait_idle("pre_rst_disp");
    access(1'b0, 1'b0, 8'h01);
    repeat (30) @(negedge CLK);
    sb_push("mid_clr_busy", 1);
    sb_check(BUSY);
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    sb_push("mid_rst_disp", 0);  sb_check(DISP_ON);
    RESET = 1'b0;
    sb_push("mid_rst_busy_len", 80);
    count_busy(n);
    sb_check(n);
    sb_push("mid_rst_ac", 0);    sb_check(CURSOR_ADDR);
    check_blank("mid_rst_blank_bad");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
